// File: rtl/instruction_fetcher.sv
// Instruction fetcher with a single-entry last-fetch buffer; hit: accept->instr_valid 1 cycle, miss: accept->mem_req 1 cycle, rsp->instr_valid 1 cycle.
// One transaction at a time: fetch_ready only in IDLE; mem request and instruction outputs held until their handshakes.
module instruction_fetcher #(
    parameter int ADDR_WIDTH    = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int WARP_ID_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [ADDR_WIDTH-1:0]    fetch_pc,
    input  logic [WARP_ID_WIDTH-1:0] fetch_warp,
    input  logic                     flush,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr,
    input  logic                     mem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0]   mem_rsp_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_WIDTH-1:0]   instr_data,
    output logic [ADDR_WIDTH-1:0]    instr_pc,
    output logic [WARP_ID_WIDTH-1:0] instr_warp,
    output logic [15:0]              hit_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [ADDR_WIDTH-1:0]    r_pc;
    logic [WARP_ID_WIDTH-1:0] r_warp;
    logic [INSTR_WIDTH-1:0]   r_data;
    logic [15:0]              r_hit_count;

    logic                     r_buf_vld;
    logic [ADDR_WIDTH-1:0]    r_buf_tag;
    logic [INSTR_WIDTH-1:0]   r_buf_data;

    logic                     w_accept;
    logic                     w_hit;
    logic                     w_rsp;

    // A flush in the accept cycle forces a miss even if the tag matches.
    assign w_accept = (r_state == S_IDLE) && fetch_valid;
    assign w_hit    = r_buf_vld && (r_buf_tag == fetch_pc) && !flush;
    assign w_rsp    = (r_state == S_WAIT) && mem_rsp_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (fetch_valid) begin
                    w_state_nxt = w_hit ? S_DELIVER : S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    w_state_nxt = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (instr_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= '0;
            r_warp      <= '0;
            r_data      <= '0;
            r_hit_count <= '0;
        end else begin
            if (w_accept) begin
                r_pc   <= fetch_pc;
                r_warp <= fetch_warp;
                if (w_hit) begin
                    r_data <= r_buf_data;
                    if (r_hit_count != 16'hFFFF) begin
                        r_hit_count <= r_hit_count + 16'd1;
                    end
                end
            end
            if (w_rsp) begin
                r_data <= mem_rsp_data;
            end
        end
    end

    // Flush wins over a same-cycle refill so stale program words never get cached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_vld  <= 1'b0;
            r_buf_tag  <= '0;
            r_buf_data <= '0;
        end else if (flush) begin
            r_buf_vld <= 1'b0;
        end else if (w_rsp) begin
            r_buf_vld  <= 1'b1;
            r_buf_tag  <= r_pc;
            r_buf_data <= mem_rsp_data;
        end
    end

    assign fetch_ready   = (r_state == S_IDLE);
    assign mem_req_valid = (r_state == S_REQUEST);
    assign mem_req_addr  = r_pc;
    assign instr_valid   = (r_state == S_DELIVER);
    assign instr_data    = r_data;
    assign instr_pc      = r_pc;
    assign instr_warp    = r_warp;
    assign hit_count     = r_hit_count;

endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: instruction address / PC width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32: instruction word width.
REQ-003 SHALL have parameter WARP_ID_WIDTH, default 2: warp identifier width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port fetch_valid  input  1  scheduler presents a fetch request.
REQ-007 SHALL have port fetch_ready  output  1  fetcher accepts a request this cycle.
REQ-008 SHALL have port fetch_pc  input  ADDR_WIDTH  address to fetch.
REQ-009 SHALL have port fetch_warp  input  WARP_ID_WIDTH  requesting warp.
REQ-010 SHALL have port flush  input  1  invalidate the last-fetch buffer, e.g. after program load.
REQ-011 SHALL have port mem_req_valid  output  1  program-memory read request.
REQ-012 SHALL have port mem_req_ready  input  1  memory accepts the request.
REQ-013 SHALL have port mem_req_addr  output  ADDR_WIDTH  read address.
REQ-014 SHALL have port mem_rsp_valid  input  1  read data valid.
REQ-015 SHALL have port mem_rsp_data  input  INSTR_WIDTH  read data.
REQ-016 SHALL have port instr_valid  output  1  instruction presented to the decoder.
REQ-017 SHALL have port instr_ready  input  1  decoder accepts the instruction.
REQ-018 SHALL have ports instr_data / instr_pc / instr_warp  outputs  INSTR_WIDTH / ADDR_WIDTH / WARP_ID_WIDTH  the fetched word, its PC, and its warp.
REQ-019 SHALL have port hit_count  output  16  saturating count of buffer hits.

Function
REQ-020 SHALL implement FSM states IDLE, REQUEST, WAIT and DELIVER; all outputs are registered or decoded from state only.
REQ-021 IDLE: fetch_ready=1, and only in IDLE.
- On fetch_valid, SHALL latch fetch_pc and fetch_warp.
- On a hit, it SHALL go to DELIVER and load the buffered word.
- On a miss, it SHALL go to REQUEST.
REQ-022 A hit SHALL be: buffer valid AND buffer tag == fetch_pc AND flush low in the same cycle.
REQ-023 REQUEST: mem_req_valid=1 and mem_req_addr=latched PC, both held stable until mem_req_ready; on mem_req_ready, go to WAIT.
REQ-024 WAIT: on mem_rsp_valid, the fetcher SHALL capture mem_rsp_data and go to DELIVER. It SHALL also write tag=latched PC, data and valid=1 into the buffer, unless flush is high in that cycle.
REQ-025 mem_rsp_valid outside WAIT SHALL be ignored, with no state or buffer change.
REQ-026 DELIVER: instr_valid=1, with instr_data/pc/warp stable until instr_ready; on instr_ready, go to IDLE.
REQ-027 Latency:
- Hit: accept edge to instr_valid high is 1 cycle.
- Miss: mem_req_valid rises 1 cycle after accept.
- Response: instr_valid rises 1 cycle after the mem_rsp_valid cycle.
REQ-028 Back-to-back: a new request SHALL be accepted at the earliest in the cycle after the instr_ready handshake, so there is one bubble.
REQ-029 flush SHALL clear buffer valid at the next edge in any state, and SHALL NOT abort an in-flight transaction.
REQ-030 hit_count SHALL increment by 1 per accepted hit and saturate at 16'hFFFF.
REQ-031 fetch_pc SHALL be compared at full ADDR_WIDTH; no alignment is assumed.

Reset
REQ-032 reset high SHALL force state IDLE immediately, independent of clk.
REQ-033 reset SHALL clear buffer valid, hit_count, mem_req_valid and instr_valid to 0, with fetch_ready=1 after reset.
REQ-034 reset mid-transaction SHALL drop the request; a memory response arriving afterward is ignored per REQ-025.
REQ-035 Data/PC/warp registers SHALL reset to 0.

Verification
REQ-036 Miss: fetch pc=0x10, warp=1; memory ready immediately, responds 0xDEADBEEF 3 cycles later -> one mem_req at 0x10; instr_valid with data=0xDEADBEEF, pc=0x10, warp=1; hit_count=0.
REQ-037 Hit: repeat pc=0x10, warp=2 -> no mem_req_valid; instr_valid 1 cycle after accept, data=0xDEADBEEF, warp=2; hit_count=1.
REQ-038 Flush: flush pulse, then fetch pc=0x10 -> mem_req issued again; and flush in the same cycle as mem_rsp_valid -> instruction delivered, next fetch of the same PC misses.
REQ-039 Backpressure: hold mem_req_ready=0 for 5 cycles, then instr_ready=0 for 4 cycles -> mem_req_addr and instr_* stable throughout; fetch_ready=0 until the handshake completes.
REQ-040 Reset mid-WAIT: assert reset between an edge and the response, then deliver a stray mem_rsp_valid -> instr_valid stays 0, fetch_ready=1, buffer invalid (next fetch misses).
REQ-041 Saturation: force 65536 hits -> hit_count holds 16'hFFFF.
